// File: rtl/fb_scan_reader.sv
// Read side of the 256x256 RGB333 framebuffer: VGA (x,y) -> read address -> 8-bit RGB, 2x scaled and centred.
// Define FB_SCAN_TESTPAT_EN to add iTestpat, which replaces memory data with a coordinate-derived pattern.
module fb_scan_reader #(
    parameter int          IMG_LOG2   = 8,
    parameter int          SCALE_LOG2 = 1,
    parameter int          X_OFS      = 144,
    parameter int          Y_OFS      = 44,
    parameter int          MEM_LAT    = 1,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iRequest,
    input  logic [10:0]           iX,
    input  logic [10:0]           iY,
`ifdef FB_SCAN_TESTPAT_EN
    input  logic                  iTestpat,
`endif
    output logic                  mem_rd_en,
    output logic [2*IMG_LOG2-1:0] mem_addr,
    input  logic [8:0]            mem_rdata,
    output logic [7:0]            oR,
    output logic [7:0]            oG,
    output logic [7:0]            oB,
    output logic                  oValid,
    output logic                  oFrame_done,
    output logic [7:0]            oFrame_cnt
);
    localparam int          D    = MEM_LAT + 1;
    localparam int          WIN  = 1 << (IMG_LOG2 + SCALE_LOG2);
    localparam logic [10:0] X_LO = 11'(X_OFS);
    localparam logic [10:0] X_HI = 11'(X_OFS + WIN - 1);
    localparam logic [10:0] Y_LO = 11'(Y_OFS);
    localparam logic [10:0] Y_HI = 11'(Y_OFS + WIN - 1);

    typedef enum logic {WAIT_FRAME, SCANNING} state_t;

    function automatic logic [7:0] expand(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    state_t                state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [2*IMG_LOG2-1:0] addr_q, addr_d;
    logic [D-1:0]          req_pipe_q, req_pipe_d;
    logic [D-1:0]          win_pipe_q, win_pipe_d;
    logic [D-1:0]          last_pipe_q, last_pipe_d;
    logic [23:0]           rgb_q, rgb_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [10:0]           dx, dy;
    logic [IMG_LOG2-1:0]   img_x, img_y;
    logic                  inwin, is_first, is_last;
    logic [8:0]            pix;
`ifdef FB_SCAN_TESTPAT_EN
    logic [D-1:0]          tp_pipe_q, tp_pipe_d;
    logic [D-1:0][8:0]     tpc_pipe_q, tpc_pipe_d;
`endif

    always_comb begin
        dx       = iX - X_LO;
        dy       = iY - Y_LO;
        img_x    = IMG_LOG2'(dx >> SCALE_LOG2);
        img_y    = IMG_LOG2'(dy >> SCALE_LOG2);
        inwin    = iRequest && (iX >= X_LO) && (iX <= X_HI) && (iY >= Y_LO) && (iY <= Y_HI);
        is_first = iRequest && (iX == X_LO) && (iY == Y_LO);
        is_last  = iRequest && (iX == X_HI) && (iY == Y_HI);
    end

    always_comb begin
        rd_en_d     = inwin;
        addr_d      = inwin ? {img_y, img_x} : addr_q;
        req_pipe_d  = {req_pipe_q[D-2:0], iRequest};
        win_pipe_d  = {win_pipe_q[D-2:0], inwin};
        last_pipe_d = {last_pipe_q[D-2:0], is_last};
        pix         = mem_rdata;
`ifdef FB_SCAN_TESTPAT_EN
        rd_en_d    = inwin && !iTestpat;
        tp_pipe_d  = {tp_pipe_q[D-2:0], iTestpat};
        tpc_pipe_d = {tpc_pipe_q[D-2:0],
                      {img_x[IMG_LOG2-1 -: 3], img_y[IMG_LOG2-1 -: 3],
                       img_x[IMG_LOG2-1 -: 3] ^ img_y[IMG_LOG2-1 -: 3]}};
        if (tp_pipe_q[D-1]) pix = tpc_pipe_q[D-1];
`endif
        // Colour regs only move when a request reaches the output stage.
        valid_d = req_pipe_q[D-1];
        rgb_d   = rgb_q;
        if (req_pipe_q[D-1])
            rgb_d = win_pipe_q[D-1] ? {expand(pix[8:6]), expand(pix[5:3]), expand(pix[2:0])}
                                    : BORDER_RGB;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        if (state_q == SCANNING && last_pipe_q[D-1]) begin
            state_d = WAIT_FRAME;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
        end
        // A new frame origin always (re)starts the scan, even mid-frame.
        if (is_first) state_d = SCANNING;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= WAIT_FRAME;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            req_pipe_q  <= '0;
            win_pipe_q  <= '0;
            last_pipe_q <= '0;
            rgb_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
`ifdef FB_SCAN_TESTPAT_EN
            tp_pipe_q   <= '0;
            tpc_pipe_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            req_pipe_q  <= req_pipe_d;
            win_pipe_q  <= win_pipe_d;
            last_pipe_q <= last_pipe_d;
            rgb_q       <= rgb_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
`ifdef FB_SCAN_TESTPAT_EN
            tp_pipe_q   <= tp_pipe_d;
            tpc_pipe_q  <= tpc_pipe_d;
`endif
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = addr_q;
    assign {oR, oG, oB} = rgb_q;
    assign oValid      = valid_q;
    assign oFrame_done = done_q;
    assign oFrame_cnt  = cnt_q;
endmodule

// File: tb/tb_fb_scan_reader.sv
// Scoreboard bench for fb_scan_reader: stimulus pushes hand-computed expectations, a negedge monitor pops and checks.
module tb_fb_scan_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iRequest = 1'b0;
    logic [10:0] iX = '0, iY = '0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [8:0]  mem_rdata = '0;
    logic [7:0]  oR, oG, oB, oFrame_cnt;
    logic        oValid, oFrame_done;
`ifdef FB_SCAN_TESTPAT_EN
    logic        iTestpat = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [23:0] val;
    } exp_t;

    exp_t aq[$], oq[$], fq[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    fb_scan_reader dut (
        .clock(clock), .reset(reset), .iRequest(iRequest), .iX(iX), .iY(iY),
`ifdef FB_SCAN_TESTPAT_EN
        .iTestpat(iTestpat),
`endif
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .oR(oR), .oG(oG), .oB(oB), .oValid(oValid),
        .oFrame_done(oFrame_done), .oFrame_cnt(oFrame_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // One-cycle memory: data word is addr[8:0] ^ 9'h1C5; a junk word when not read.
    always @(posedge clock) mem_rdata <= mem_rd_en ? (mem_addr[8:0] ^ 9'h1C5) : 9'h092;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (mem_rd_en === 1'b1) begin
                if (aq.size() == 0) chk("rd_en_unexpected", {31'd0, mem_rd_en}, 32'd0);
                else begin
                    e = aq.pop_front();
                    chk("rd_cycle", cyc, e.due);
                    chk("mem_addr", {16'd0, mem_addr}, {8'd0, e.val});
                end
            end else if (aq.size() != 0 && aq[0].due <= cyc) begin
                e = aq.pop_front();
                chk("rd_en_missing", {31'd0, mem_rd_en}, 32'd1);
            end
            if (oValid === 1'b1) begin
                if (oq.size() == 0) chk("ovalid_unexpected", {31'd0, oValid}, 32'd0);
                else begin
                    e = oq.pop_front();
                    chk("out_cycle", cyc, e.due);
                    chk("out_rgb", {8'd0, oR, oG, oB}, {8'd0, e.val});
                end
            end else if (oq.size() != 0 && oq[0].due <= cyc) begin
                e = oq.pop_front();
                chk("ovalid_missing", {31'd0, oValid}, 32'd1);
            end
            if (oFrame_done === 1'b1) begin
                if (fq.size() == 0) chk("done_unexpected", {31'd0, oFrame_done}, 32'd0);
                else begin
                    e = fq.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("frame_cnt", {24'd0, oFrame_cnt}, {8'd0, e.val});
                end
            end else if (fq.size() != 0 && fq[0].due <= cyc) begin
                e = fq.pop_front();
                chk("done_missing", {31'd0, oFrame_done}, 32'd1);
            end
        end
    end

    task automatic issue(input int x, input int y, input bit rd, input logic [15:0] a,
                         input logic [23:0] rgb, input bit done, input int cnt);
        iRequest = 1'b1;
        iX = 11'(x);
        iY = 11'(y);
        if (rd) aq.push_back('{due: cyc + 1, val: {8'd0, a}});
        oq.push_back('{due: cyc + 3, val: rgb});
        if (done) fq.push_back('{due: cyc + 3, val: 24'(cnt)});
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        iRequest = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_rgb"}, {8'd0, oR, oG, oB}, 32'd0);
        chk({tag, "_valid"}, {31'd0, oValid}, 32'd0);
        chk({tag, "_done"}, {31'd0, oFrame_done}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, oFrame_cnt}, 32'd0);
    endtask

    // Origin, an interior pixel, and the last window pixel of the frame.
    task automatic frame(input int exp_cnt);
        issue(144, 44, 1, 16'h0000, 24'hFF00B6, 0, 0);
        issue(400, 300, 1, 16'h8080, 24'hB600B6, 0, 0);
        issue(655, 555, 1, 16'hFFFF, 24'h00FF49, 1, exp_cnt);
        idle(3);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_zero("reset");

        issue(144, 44, 1, 16'h0000, 24'hFF00B6, 0, 0);
        idle(4);
        issue(145, 44, 1, 16'h0000, 24'hFF00B6, 0, 0);
        issue(146, 45, 1, 16'h0001, 24'hFF0092, 0, 0);
        issue(144, 46, 1, 16'h0100, 24'h6D00B6, 0, 0);
        idle(4);

        issue(100, 300, 0, 16'h0000, 24'h000000, 0, 0);
        issue(656, 44, 0, 16'h0000, 24'h000000, 0, 0);
        issue(143, 44, 0, 16'h0000, 24'h000000, 0, 0);
        issue(144, 43, 0, 16'h0000, 24'h000000, 0, 0);
        issue(144, 556, 0, 16'h0000, 24'h000000, 0, 0);
        issue(654, 554, 1, 16'hFFFF, 24'h00FF49, 0, 0);
        idle(4);

`ifdef FB_SCAN_TESTPAT_EN
        iTestpat = 1'b1;
        issue(592, 108, 0, 16'h0000, 24'hFF24DB, 0, 0);
        idle(1);
        iTestpat = 1'b0;
        idle(4);
`endif

        for (int k = 1; k <= 257; k++) frame(k % 256);

        issue(144, 44, 1, 16'h0000, 24'hFF00B6, 0, 0);
        issue(400, 300, 1, 16'h8080, 24'hB600B6, 0, 0);
        iRequest = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        aq.delete();
        oq.delete();
        fq.delete();
        check_zero("midreset");

        // Tail of the interrupted frame must not be counted.
        issue(655, 555, 1, 16'hFFFF, 24'h00FF49, 0, 0);
        idle(4);
        frame(1);
        idle(6);

        chk("rd_queue_empty", aq.size(), 32'd0);
        chk("out_queue_empty", oq.size(), 32'd0);
        chk("done_queue_empty", fq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
